// File: rtl/uart_arb_defs.sv
// Shared state encodings and default parameters for the UART TX arbiter.
package uart_arb_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_GAP_TIMEOUT  = 1000;
    localparam int DEF_BUSY_TIMEOUT = 8;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester after last_owner.
module rr_select
    import uart_arb_defs::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    logic          found;
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(last_owner) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one uart_tx from N requesters.
module uart_tx_arbiter
    import uart_arb_defs::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int GAP_TIMEOUT  = DEF_GAP_TIMEOUT,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               arb_busy,
    output logic               pkt_done,
    output logic               err_timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = $clog2(GAP_TIMEOUT) + 1;
    localparam int BW = $clog2(BUSY_TIMEOUT) + 1;

    arb_state_e     state, state_nxt;
    logic [IW-1:0]  owner, last_owner, rr_idx;
    logic [N_REQ-1:0] rr_gnt;
    logic           last_flag;
    logic [GW-1:0]  gap_cnt;
    logic [BW-1:0]  busy_cnt;
    logic           own_valid, own_last;
    logic [7:0]     own_data;
    logic           xfer, gap_tmo, busy_tmo, done;

    rr_select #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req        (req_valid),
        .last_owner (last_owner),
        .gnt        (rr_gnt),
        .idx        (rr_idx)
    );

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = req_data[{owner, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (|req_valid) state_nxt = SEND;
            SEND: begin
                if (xfer)         state_nxt = WAIT_BUSY;
                else if (gap_tmo) state_nxt = IDLE;
            end
            WAIT_BUSY: begin
                if (tx_busy)       state_nxt = WAIT_DONE;
                else if (busy_tmo) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = last_flag ? IDLE : SEND;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        xfer      = (state == SEND) && own_valid;
        gap_tmo   = (state == SEND) && !own_valid
                    && (gap_cnt >= GW'(GAP_TIMEOUT - 1));
        busy_tmo  = (state == WAIT_BUSY) && !tx_busy
                    && (busy_cnt >= BW'(BUSY_TIMEOUT - 1));
        done      = (state == WAIT_DONE) && !tx_busy && last_flag;
        req_ready = (state == SEND) ? grant : '0;
        arb_busy  = (state != IDLE);
    end

    // Pulses are registered so they appear the cycle after the triggering event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant       <= '0;
            owner       <= '0;
            last_owner  <= IW'(N_REQ - 1);
            last_flag   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            pkt_done    <= 1'b0;
            err_timeout <= 1'b0;
            gap_cnt     <= '0;
            busy_cnt    <= '0;
        end else begin
            tx_start    <= xfer;
            pkt_done    <= done;
            err_timeout <= gap_tmo | busy_tmo;
            if (state == IDLE && |req_valid) begin
                grant <= rr_gnt;
                owner <= rr_idx;
            end
            if (done || gap_tmo || busy_tmo) grant <= '0;
            if (done || gap_tmo) last_owner <= owner;
            if (xfer) begin
                tx_data   <= own_data;
                last_flag <= own_last;
            end
            if (xfer || gap_tmo || state == IDLE)
                gap_cnt <= '0;
            else if (state == SEND && gap_cnt != GW'(GAP_TIMEOUT))
                gap_cnt <= gap_cnt + 1'b1;
            if (state == WAIT_BUSY && !tx_busy && !busy_tmo) begin
                if (busy_cnt != BW'(BUSY_TIMEOUT))
                    busy_cnt <= busy_cnt + 1'b1;
            end else begin
                busy_cnt <= '0;
            end
        end
    end

endmodule
